// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, total derivation,
// sync-region boundaries and small helpers used by the raster generator
// and the display stage.
package vga_timing_pkg;

    // Width of the raster counters and the largest total they can hold
    localparam int CNT_W     = 10;
    localparam int CNT_LIMIT = 1024;

    // 640x480@60 default timing, pixel clock derived from a 50 MHz system clock
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam int   DEF_CLK_DIV  = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    // Total period of one axis: visible + front porch + sync + back porch
    function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Sync regions are half-open: [START, END)
    localparam int DEF_HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    // Registered status flags that travel alongside row/col
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic vnotactive;
        logic frame_start;
    } vga_flags_t;

    // Half-open window test on a full-width count; bounds carry one extra
    // bit so an end boundary equal to CNT_LIMIT is still representable
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W:0]   lo,
                                       input logic [CNT_W:0]   hi);
        logic [CNT_W:0] ext;
        ext = {1'b0, cnt};
        return (ext >= lo) && (ext < hi);
    endfunction

    // Flag values while the raster is held at (0,0) by reset
    function automatic vga_flags_t reset_flags(input logic pol);
        vga_flags_t f;
        f.hsync       = ~pol;
        f.vsync       = ~pol;
        f.active      = 1'b1;
        f.vnotactive  = 1'b0;
        f.frame_start = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// Modulo-(MAX+1) counter with enable. wrap marks the enabled cycle on which
// the count is at MAX and returns to zero, so it can enable the next stage.
module wrap_counter #(
    parameter int W   = 10,
    parameter int MAX = 799
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_C  = W'(MAX);
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};

    // Wrap event: enabled and at the terminal count
    always_comb begin
        wrap = en && (cnt == MAX_C);
    end

    // Count register: hold, advance, or return to zero at the terminal count
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= ZERO_C;
        end else if (wrap) begin
            cnt <= ZERO_C;
        end else if (en) begin
            cnt <= cnt + W'(1'b1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. A clock divider produces the pixel strobe,
// chained horizontal/vertical counters produce col/row, and the sync and
// blanking flags are registered from the next-state counts so they switch on
// the same edge as row/col.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             pix_en,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             vnotactive,
    output logic             frame_start
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX_C    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W:0]   H_ACTIVE_C   = (CNT_W + 1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACTIVE_C   = (CNT_W + 1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_START_C   = (CNT_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END_C     = (CNT_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_START_C   = (CNT_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END_C     = (CNT_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W - 1){1'b0}}, 1'b1};

    // Reject timings the 10-bit counters cannot represent
    if (H_TOTAL > CNT_LIMIT) begin : g_h_total_chk
        $error("vga_timing: H_TOTAL %0d exceeds counter range", H_TOTAL);
    end
    if (V_TOTAL > CNT_LIMIT) begin : g_v_total_chk
        $error("vga_timing: V_TOTAL %0d exceeds counter range", V_TOTAL);
    end
    if (CLK_DIV < 1) begin : g_div_chk
        $error("vga_timing: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt_r;
    logic             div_wrap_s;
    logic [CNT_W-1:0] hcnt_r;
    logic             h_wrap_s;
    logic [CNT_W-1:0] vcnt_r;
    logic             v_wrap_s;
    logic [CNT_W-1:0] h_nxt_s;
    logic [CNT_W-1:0] v_nxt_s;
    vga_flags_t       flags_nxt_s;
    vga_flags_t       flags_r;

    // Pixel divider runs every clock; its wrap is the pixel strobe
    wrap_counter #(.W(DIV_W), .MAX(CLK_DIV - 1)) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .en   (1'b1),
        .cnt  (div_cnt_r),
        .wrap (div_wrap_s)
    );

    // Horizontal counter advances once per pixel strobe
    wrap_counter #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
        .CLK  (CLK),
        .RST  (RST),
        .en   (div_wrap_s),
        .cnt  (hcnt_r),
        .wrap (h_wrap_s)
    );

    // Vertical counter advances on each line wrap; its wrap is the frame wrap
    wrap_counter #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
        .CLK  (CLK),
        .RST  (RST),
        .en   (h_wrap_s),
        .cnt  (vcnt_r),
        .wrap (v_wrap_s)
    );

    // Pixel strobe decoded from the divider count (constant 1 when CLK_DIV is 1)
    always_comb begin
        pix_en = (div_cnt_r == DIV_MAX_C);
    end

    // Next-state counts, mirroring what the counters load on the coming edge
    always_comb begin
        h_nxt_s = hcnt_r;
        v_nxt_s = vcnt_r;
        if (h_wrap_s) begin
            h_nxt_s = CNT_ZERO_C;
        end else if (div_wrap_s) begin
            h_nxt_s = hcnt_r + CNT_ONE_C;
        end else begin
            h_nxt_s = hcnt_r;
        end
        if (v_wrap_s) begin
            v_nxt_s = CNT_ZERO_C;
        end else if (h_wrap_s) begin
            v_nxt_s = vcnt_r + CNT_ONE_C;
        end else begin
            v_nxt_s = vcnt_r;
        end
    end

    // Flag decode from the next-state counts so flags align with row/col
    always_comb begin
        flags_nxt_s             = reset_flags(SYNC_POL);
        flags_nxt_s.hsync       = in_window(h_nxt_s, HS_START_C, HS_END_C) ? SYNC_POL : ~SYNC_POL;
        flags_nxt_s.vsync       = in_window(v_nxt_s, VS_START_C, VS_END_C) ? SYNC_POL : ~SYNC_POL;
        flags_nxt_s.active      = ({1'b0, h_nxt_s} < H_ACTIVE_C) && ({1'b0, v_nxt_s} < V_ACTIVE_C);
        flags_nxt_s.vnotactive  = ({1'b0, v_nxt_s} >= V_ACTIVE_C);
        flags_nxt_s.frame_start = v_wrap_s;
    end

    // Flag register; reset returns to the (0,0) values with sync deasserted
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            flags_r <= reset_flags(SYNC_POL);
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    // Port mapping of the registered counts and flags
    always_comb begin
        col         = hcnt_r;
        row         = vcnt_r;
        hsync       = flags_r.hsync;
        vsync       = flags_r.vsync;
        active      = flags_r.active;
        vnotactive  = flags_r.vnotactive;
        frame_start = flags_r.frame_start;
    end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three instances (default 640x480 timing,
// a small CLK_DIV=2 raster, a small CLK_DIV=1 raster with active-high sync)
// share one randomly pulsed asynchronous reset. Expected outputs come from an
// arithmetic model of elapsed clocks since reset release.
module tb_vga_timing;

    localparam int NDUT = 3;

    typedef struct {
        int d;
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
    } cfg_t;

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
            1:       c = '{2, 8, 2, 3, 3, 6, 2, 2, 2, 1'b0};
            default: c = '{1, 10, 1, 4, 2, 5, 1, 3, 2, 1'b1};
        endcase
        return c;
    endfunction

    // Expected {pix_en, col, row, hsync, vsync, active, vnotactive, frame_start}
    // after k clock edges since reset release.
    function automatic logic [25:0] model(input cfg_t c, input longint k);
        longint p;
        int ht, vt, cl, rw;
        logic pe, hsy, vsy, act, vna, fs;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        p   = k / longint'(c.d);
        cl  = int'(p % longint'(ht));
        rw  = int'((p / longint'(ht)) % longint'(vt));
        pe  = ((k % longint'(c.d)) == longint'(c.d - 1));
        hsy = (cl >= c.ha + c.hf && cl < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
        vsy = (rw >= c.va + c.vf && rw < c.va + c.vf + c.vs) ? c.pol : !c.pol;
        act = (cl < c.ha) && (rw < c.va);
        vna = (rw >= c.va);
        fs  = (p > 0) && ((k % longint'(c.d)) == 0) && ((p % longint'(ht * vt)) == 0);
        return {pe, 10'(cl), 10'(rw), hsy, vsy, act, vna, fs};
    endfunction

    logic       CLK;
    logic       RST;
    logic       pix_en_w      [NDUT];
    logic [9:0] col_w         [NDUT];
    logic [9:0] row_w         [NDUT];
    logic       hsync_w       [NDUT];
    logic       vsync_w       [NDUT];
    logic       active_w      [NDUT];
    logic       vnotactive_w  [NDUT];
    logic       frame_start_w [NDUT];

    vga_timing u_dut0 (
        .CLK(CLK), .RST(RST), .pix_en(pix_en_w[0]), .col(col_w[0]), .row(row_w[0]),
        .hsync(hsync_w[0]), .vsync(vsync_w[0]), .active(active_w[0]),
        .vnotactive(vnotactive_w[0]), .frame_start(frame_start_w[0])
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) u_dut1 (
        .CLK(CLK), .RST(RST), .pix_en(pix_en_w[1]), .col(col_w[1]), .row(row_w[1]),
        .hsync(hsync_w[1]), .vsync(vsync_w[1]), .active(active_w[1]),
        .vnotactive(vnotactive_w[1]), .frame_start(frame_start_w[1])
    );

    vga_timing #(
        .H_ACTIVE(10), .H_FP(1), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(3), .V_BP(2),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) u_dut2 (
        .CLK(CLK), .RST(RST), .pix_en(pix_en_w[2]), .col(col_w[2]), .row(row_w[2]),
        .hsync(hsync_w[2]), .vsync(vsync_w[2]), .active(active_w[2]),
        .vnotactive(vnotactive_w[2]), .frame_start(frame_start_w[2])
    );

    function automatic logic [25:0] observe(input int i);
        return {pix_en_w[i], col_w[i], row_w[i], hsync_w[i], vsync_w[i],
                active_w[i], vnotactive_w[i], frame_start_w[i]};
    endfunction

    logic [25:0] exp_q [NDUT][$];
    longint      k_edges = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          fs_exp  [NDUT] = '{0, 0, 0};
    int          fs_dut  [NDUT] = '{0, 0, 0};

    // Clock: posedge at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Clock edges elapsed since reset release
    always @(posedge CLK) begin
        if (!RST) k_edges <= 0;
        else      k_edges <= k_edges + 1;
    end

    // Reference side: push the expected outputs for this sample point
    always @(negedge CLK) begin
        logic [25:0] e;
        for (int i = 0; i < NDUT; i++) begin
            e = model(cfg_of(i), RST ? k_edges : 64'd0);
            exp_q[i].push_back(e);
            if (e[0]) fs_exp[i]++;
        end
    end

    // Monitor side: pop and compare against the DUT outputs
    always @(negedge CLK) begin
        logic [25:0] e;
        logic [25:0] g;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            g = observe(i);
            if (g[0]) fs_dut[i]++;
            checks++;
            if (exp_q[i].size() == 0) begin
                errors++;
                $display("FAIL sb_empty dut%0d t=%0t got no expectation required one queued", i, $time);
            end else begin
                e = exp_q[i].pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL sb dut%0d t=%0t got pe=%b col=%0d row=%0d hs/vs/act/vna/fs=%b required pe=%b col=%0d row=%0d hs/vs/act/vna/fs=%b",
                             i, $time, g[25], g[24:15], g[14:5], g[4:0], e[25], e[24:15], e[14:5], e[4:0]);
                end
            end
        end
    end

    // Stimulus: initial reset, long free run, random asynchronous mid-frame resets
    initial begin
        RST = 1'b1;
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (4000) @(posedge CLK);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(200, 3000)) @(posedge CLK);
            #2 RST = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge CLK);
            #2 RST = 1'b1;
        end
        repeat (3000) @(posedge CLK);
        @(negedge CLK);
        #3;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (fs_dut[i] != fs_exp[i]) begin
                errors++;
                $display("FAIL fs_count dut%0d got %0d required %0d", i, fs_dut[i], fs_exp[i]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
